// File: rtl/camera_frame_reader.sv
// HCLK-side frame reader: requests a capture over a four-phase DATA_VALID/DATA_READY
// handshake, then streams the frame buffer out as RGB565 pixels on a valid/ready port.
module camera_frame_reader #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              START,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic [ADDR_W-1:0] DualRAM_RADDR,
    input  logic [31:0]       DualRAM_RDATA,
    output logic [15:0]       PIX_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              PIX_LAST,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_STREAM} state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rdy_s;
    logic                    dv_q;
    logic [ADDR_W-1:0]       rd_idx_q;
    logic [ADDR_W-1:0]       out_idx_q;
    logic                    rd_all_q;
    logic                    in_flight_q;
    logic [1:0]              cnt_q;
    logic [15:0]             head_q;
    logic [15:0]             skid_q;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    last_out;
    logic [2:0]              occ;
    logic                    unused_rdata_hi;

    assign unused_rdata_hi = ^DualRAM_RDATA[31:16];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], DATA_READY};
        end
    end
    assign rdy_s = sync_q[SYNC_STAGES-1];

    assign PIX_VALID     = (cnt_q != 2'd0);
    assign PIX_DATA      = head_q;
    assign last_out      = (out_idx_q == LAST_IDX);
    assign PIX_LAST      = PIX_VALID & last_out;
    assign pop           = PIX_VALID & PIX_READY;
    assign DONE          = pop & last_out;
    assign push          = in_flight_q;
    assign BUSY          = (state_q != S_IDLE);
    assign DATA_VALID    = dv_q;
    assign DualRAM_RADDR = rd_idx_q;

    // A pop implies cnt_q >= 1, so occupancy never underflows.
    assign occ   = 3'(cnt_q) + 3'(in_flight_q) - 3'(pop);
    assign issue = (state_q == S_STREAM) && !rd_all_q && (occ < 3'd2);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            dv_q        <= 1'b0;
            rd_idx_q    <= '0;
            out_idx_q   <= '0;
            rd_all_q    <= 1'b0;
            in_flight_q <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q  <= S_REQ;
                        dv_q     <= 1'b1;
                        rd_idx_q <= '0;
                    end
                end
                S_REQ: begin
                    if (rdy_s) begin
                        state_q <= S_REL;
                        dv_q    <= 1'b0;
                    end
                end
                S_REL: begin
                    // Camera has released the buffer; RAM contents are now stable.
                    if (!rdy_s) begin
                        state_q   <= S_STREAM;
                        rd_idx_q  <= '0;
                        out_idx_q <= '0;
                        rd_all_q  <= 1'b0;
                    end
                end
                default: begin
                    if (DONE) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase

            // The last index is held rather than incremented so the counter never wraps.
            if (issue) begin
                if (rd_idx_q == LAST_IDX) begin
                    rd_all_q <= 1'b1;
                end else begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                end
            end
            in_flight_q <= issue;

            if (pop && !last_out) begin
                out_idx_q <= out_idx_q + 1'b1;
            end

            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        head_q <= DualRAM_RDATA[15:0];
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= DualRAM_RDATA[15:0];
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end else if (push) begin
                        skid_q <= DualRAM_RDATA[15:0];
                        cnt_q  <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= skid_q;
                        if (push) begin
                            skid_q <= DualRAM_RDATA[15:0];
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_reader.sv
// Self-checking bench for camera_frame_reader: a 16-pixel and a 1-pixel instance, each with
// a camera handshake model and a RAM model; streamed pixels are checked against RAM contents.
module tb_camera_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hresetn;
    logic        start;
    logic        pix_ready;
    logic        sel;
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] mema [16];
    logic [31:0] memb;

    wire  [1:0]  start_v;
    wire  [1:0]  dv_v;
    wire  [1:0]  dr_v;
    wire  [1:0]  pv_v;
    wire  [1:0]  pl_v;
    wire  [1:0]  busy_v;
    wire  [1:0]  done_v;
    wire  [16:0] raddr_v [2];
    wire  [15:0] pd_v    [2];
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    assign start_v[0] = start & ~sel;
    assign start_v[1] = start & sel;

    camera_frame_reader #(.FRAME_PIXELS(16), .ADDR_W(17), .SYNC_STAGES(2)) dut_a (
        .HCLK(clk), .HRESETn(hresetn), .START(start_v[0]), .DATA_VALID(dv_v[0]),
        .DATA_READY(dr_v[0]), .DualRAM_RADDR(raddr_v[0]), .DualRAM_RDATA(rdata_a),
        .PIX_DATA(pd_v[0]), .PIX_VALID(pv_v[0]), .PIX_READY(pix_ready),
        .PIX_LAST(pl_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0])
    );

    camera_frame_reader #(.FRAME_PIXELS(1), .ADDR_W(17), .SYNC_STAGES(2)) dut_b (
        .HCLK(clk), .HRESETn(hresetn), .START(start_v[1]), .DATA_VALID(dv_v[1]),
        .DATA_READY(dr_v[1]), .DualRAM_RADDR(raddr_v[1]), .DualRAM_RDATA(rdata_b),
        .PIX_DATA(pd_v[1]), .PIX_VALID(pv_v[1]), .PIX_READY(pix_ready),
        .PIX_LAST(pl_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1])
    );

    // Camera: raise DATA_READY 20 cycles after DATA_VALID rises, drop it 5 cycles after it falls.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cam
        logic dr = 1'b0;
        int   rise_cnt = 0;
        int   fall_cnt = 0;
        always @(posedge clk) begin
            if (dv_v[gi]) begin
                fall_cnt <= 0;
                if (rise_cnt == 19) dr <= 1'b1;
                else                rise_cnt <= rise_cnt + 1;
            end else begin
                rise_cnt <= 0;
                if (dr) begin
                    if (fall_cnt == 4) dr <= 1'b0;
                    else               fall_cnt <= fall_cnt + 1;
                end
            end
        end
        assign dr_v[gi] = dr;
    end

    always @(posedge clk) rdata_a <= (raddr_v[0] < 17'd16) ? mema[raddr_v[0][3:0]] : 32'hDEADBEEF;
    always @(posedge clk) rdata_b <= (raddr_v[1] == 17'd0) ? memb : 32'hDEADBEEF;

    wire        cur_dv    = dv_v[sel];
    wire        cur_dr    = dr_v[sel];
    wire        cur_pv    = pv_v[sel];
    wire        cur_pl    = pl_v[sel];
    wire        cur_busy  = busy_v[sel];
    wire        cur_done  = done_v[sel];
    wire [16:0] cur_raddr = sel ? raddr_v[1] : raddr_v[0];
    wire [15:0] cur_pd    = sel ? pd_v[1] : pd_v[0];

    function automatic logic [15:0] exp_pix(input int k);
        logic [31:0] w;
        w = sel ? memb : mema[k];
        return w[15:0];
    endfunction

    // mode 0: PIX_READY held high; mode 1: random ready plus a 10-cycle stall at pixel 7.
    // abort_at >= 0 returns right after that many pixels have been accepted.
    task automatic run_frame(input int mode, input bit pulses, input int abort_at);
        int n = sel ? 1 : 16;
        int acc = 0, cyc = 0, fell_cyc = -1, first_cyc = -1, first_acc = -1, last_acc = -1;
        int stall_left = 0;
        bit dr_seen = 0, done_seen = 0, stalled7 = 0, pulsed3 = 0, prev_stall = 0;
        bit dv_bad = 0, addr_bad = 0, busy_bad = 0, stall_bad = 0, done_bad = 0, last_bad = 0;
        logic [15:0] prev_data = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (cur_dv !== 1'b1) begin
            failures++; $display("FAIL dv_rise: DATA_VALID=%b expected 1", cur_dv);
        end
        while (!done_seen && cyc < 2000) begin
            cyc++;
            if (cur_busy !== 1'b1) busy_bad = 1;
            if (cur_raddr >= 17'(n)) addr_bad = 1;
            if (cur_dr) dr_seen = 1;
            if (!dr_seen && cur_dv !== 1'b1) dv_bad = 1;
            if (cur_pv && cur_dv !== 1'b0) dv_bad = 1;
            if (dr_seen && !cur_dr && fell_cyc < 0) fell_cyc = cyc;
            if (cur_pv && first_cyc < 0) first_cyc = cyc;
            if (prev_stall && (cur_pv !== 1'b1 || cur_pd !== prev_data)) stall_bad = 1;
            if (cur_pv && cur_pl !== (acc == n - 1)) last_bad = 1;
            if (abort_at >= 0 && acc == abort_at) return;
            if (pulses && cyc == 5) start = 1'b1;
            if (pulses && acc == 3 && cur_pv && !pulsed3) begin
                start = 1'b1; pulsed3 = 1;
            end
            if (mode == 0) begin
                pix_ready = 1'b1;
            end else begin
                if (cur_pv && acc == 7 && !stalled7) begin
                    stalled7 = 1; stall_left = 10;
                end
                if (stall_left > 0) begin
                    pix_ready = 1'b0; stall_left--;
                end else begin
                    pix_ready = 1'($urandom_range(0, 1));
                end
            end
            #1;
            if (cur_pv && pix_ready) begin
                checks++;
                if (cur_pd !== exp_pix(acc)) begin
                    failures++;
                    $display("FAIL pix_data[%0d]: got %h expected %h", acc, cur_pd, exp_pix(acc));
                end
                checks++;
                if (cur_done !== (acc == n - 1)) begin
                    failures++;
                    $display("FAIL done_at[%0d]: DONE=%b expected %b", acc, cur_done, acc == n - 1);
                end
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                acc++;
                if (acc >= n) begin
                    done_seen = 1;
                    if (pulses) start = 1'b1;
                end
            end else if (cur_done !== 1'b0) begin
                done_bad = 1;
            end
            prev_stall = cur_pv && !pix_ready;
            prev_data  = cur_pd;
            @(negedge clk); start = 1'b0;
        end
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL frame_timeout: accepted %0d of %0d pixels", acc, n);
        end
        checks++;
        if (cur_busy !== 1'b0) begin
            failures++; $display("FAIL busy_after_done: BUSY=%b expected 0", cur_busy);
        end
        checks++;
        if ({dv_bad, addr_bad, busy_bad, stall_bad, done_bad, last_bad} !== 6'b0) begin
            failures++;
            $display("FAIL frame_flags: dv/addr/busy/stall/done/last=%b expected 000000",
                     {dv_bad, addr_bad, busy_bad, stall_bad, done_bad, last_bad});
        end
        // DR fall -> 2 sync flops -> STREAM -> read -> RAM -> FIFO head.
        checks++;
        if (first_cyc - fell_cyc != 5) begin
            failures++;
            $display("FAIL first_valid_latency: got %0d cycles expected 5", first_cyc - fell_cyc);
        end
        if (mode == 0) begin
            checks++;
            if (last_acc - first_acc != n - 1 || first_acc != first_cyc) begin
                failures++;
                $display("FAIL no_bubbles: span %0d expected %0d", last_acc - first_acc, n - 1);
            end
        end
        if (pulses) begin
            repeat (3) @(negedge clk);
            checks++;
            if (cur_busy !== 1'b0 || cur_dv !== 1'b0) begin
                failures++;
                $display("FAIL start_in_done_ignored: BUSY=%b DATA_VALID=%b expected 0 0",
                         cur_busy, cur_dv);
            end
        end
        $display("frame sel=%0d mode=%0d pulses=%0d accepted=%0d cycles=%0d", sel, mode, pulses, acc, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({dv_v[i], pv_v[i], pl_v[i], busy_v[i], done_v[i]} !== 5'b0 ||
                raddr_v[i] !== 17'd0 || pd_v[i] !== 16'd0) begin
                failures++;
                $display("FAIL %s[%0d]: dv/pv/pl/busy/done=%b raddr=%h data=%h expected all 0",
                         tag, i, {dv_v[i], pv_v[i], pl_v[i], busy_v[i], done_v[i]},
                         raddr_v[i], pd_v[i]);
            end
        end
    endtask

    task automatic test_reset;
        hresetn = 1'b0; start = 1'b0; pix_ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < 16; i++) mema[i] = 32'hABCD0000 | 32'(i);
        memb = 32'h1234BEEF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        hresetn = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_stream_ready;
        sel = 1'b0;
        run_frame(0, 1'b0, -1);
    endtask

    task automatic test_backpressure;
        sel = 1'b0;
        for (int i = 0; i < 16; i++) mema[i] = $urandom;
        run_frame(1, 1'b0, -1);
    endtask

    task automatic test_single_pixel;
        sel = 1'b1;
        memb = $urandom;
        run_frame(0, 1'b0, -1);
        memb = $urandom;
        run_frame(1, 1'b0, -1);
    endtask

    task automatic test_start_ignored;
        sel = 1'b0;
        for (int i = 0; i < 16; i++) mema[i] = $urandom;
        run_frame(0, 1'b1, -1);
    endtask

    task automatic test_back_to_back;
        sel = 1'b0;
        run_frame(1, 1'b0, -1);
        run_frame(0, 1'b0, -1);
    endtask

    task automatic test_reset_mid_stream;
        sel = 1'b0;
        for (int i = 0; i < 16; i++) mema[i] = $urandom;
        run_frame(0, 1'b0, 5);
        #2 hresetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        hresetn = 1'b1;
        @(negedge clk);
        run_frame(0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_stream_ready();
        test_backpressure();
        test_single_pixel();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
